// File: rtl/txpause_gate.sv
`default_nettype none
// ============================================================================
// Module   : txpause_gate
// Purpose  : 64-bit AXIS TX gate that holds new frames off while the peer has
//            the link paused (802.3x), through a 1-cycle registered skid stage.
// Options  : define TXPAUSE_STATS_EN to build the pause statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module txpause_gate #(
  parameter int RESUME_DELAY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_tx_pause_honor,
  input  logic        rx_pause_active,
  input  logic [63:0] s_tdata,
  input  logic [7:0]  s_tkeep,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  input  logic        s_tuser,
  output logic        s_tready,
  output logic [63:0] m_tdata,
  output logic [7:0]  m_tkeep,
  output logic        m_tvalid,
  output logic        m_tlast,
  output logic        m_tuser,
  input  logic        m_tready,
  output logic        tx_paused,
  output logic [31:0] stat_pause_cycles,
  output logic [15:0] stat_pause_events
);

  localparam int c_CNT_W = (RESUME_DELAY < 1) ? 1 : $clog2(RESUME_DELAY + 1);
  localparam logic [c_CNT_W-1:0] c_RESUME_LOAD = c_CNT_W'(RESUME_DELAY);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FRAME  = 2'd1,
    S_PAUSED = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_CNT_W-1:0]  r_resume_cnt;
  logic                w_pause_req;
  logic                w_idle_block;
  logic                w_accept;
  logic                w_enter_pause;
  logic                w_gate_nxt;
  logic                w_main_free;
  logic                w_skid_nxt;
  logic                r_ready;
  logic                r_tx_paused;
  logic                r_m_valid;
  logic                r_sk_valid;
  logic [73:0]         r_main;
  logic [73:0]         r_skid;
  logic [73:0]         w_in_beat;

  // Counter is reloaded every paused cycle, so the hold-off runs from the first low cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resume_cnt <= '0;
    end else if (rx_pause_active) begin
      r_resume_cnt <= c_RESUME_LOAD;
    end else if (r_resume_cnt != '0) begin
      r_resume_cnt <= r_resume_cnt - 1'b1;
    end
  end

  assign w_pause_req  = cfg_tx_pause_honor & (rx_pause_active | (r_resume_cnt != '0));
  // Masking here keeps a frame from starting in the very cycle idle sees the request.
  assign w_idle_block = (r_state == S_IDLE) & w_pause_req;
  assign s_tready     = r_ready & ~rst & ~w_idle_block;
  assign w_accept     = s_tvalid & s_tready;
  assign w_in_beat    = {s_tuser, s_tlast, s_tkeep, s_tdata};

  always_comb begin
    w_state_nxt   = r_state;
    w_enter_pause = 1'b0;
    w_gate_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = s_tlast ? S_IDLE : S_FRAME;
        end else if (w_pause_req) begin
          w_state_nxt   = S_PAUSED;
          w_enter_pause = 1'b1;
        end
      end
      S_FRAME: begin
        if (w_accept && s_tlast) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PAUSED: begin
        if (!w_pause_req) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    case (w_state_nxt)
      S_IDLE:  w_gate_nxt = ~w_pause_req;
      S_FRAME: w_gate_nxt = 1'b1;
      default: w_gate_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_tx_paused <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tx_paused <= (w_state_nxt == S_PAUSED);
    end
  end

  assign w_main_free = ~r_m_valid | m_tready;
  assign w_skid_nxt  = r_sk_valid ? ~w_main_free : (w_accept & ~w_main_free);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main     <= '0;
      r_skid     <= '0;
      r_m_valid  <= 1'b0;
      r_sk_valid <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      if (w_main_free) begin
        if (r_sk_valid) begin
          r_main    <= r_skid;
          r_m_valid <= 1'b1;
        end else if (w_accept) begin
          r_main    <= w_in_beat;
          r_m_valid <= 1'b1;
        end else begin
          r_m_valid <= 1'b0;
        end
      end else if (w_accept) begin
        r_skid <= w_in_beat;
      end
      r_sk_valid <= w_skid_nxt;
      r_ready    <= ~w_skid_nxt & w_gate_nxt;
    end
  end

  assign m_tdata   = r_main[63:0];
  assign m_tkeep   = r_main[71:64];
  assign m_tlast   = r_main[72];
  assign m_tuser   = r_main[73];
  assign m_tvalid  = r_m_valid;
  assign tx_paused = r_tx_paused;

`ifdef TXPAUSE_STATS_EN
  logic [31:0] r_stat_cycles;
  logic [15:0] r_stat_events;
  logic        w_count_cycle;

  // The entry cycle already has s_tready held low, so it counts as paused time.
  assign w_count_cycle = (r_state == S_PAUSED) | w_enter_pause;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_cycles <= '0;
      r_stat_events <= '0;
    end else begin
      if (w_count_cycle && (r_stat_cycles != 32'hFFFF_FFFF)) begin
        r_stat_cycles <= r_stat_cycles + 32'd1;
      end
      if (w_enter_pause && (r_stat_events != 16'hFFFF)) begin
        r_stat_events <= r_stat_events + 16'd1;
      end
    end
  end

  assign stat_pause_cycles = r_stat_cycles;
  assign stat_pause_events = r_stat_events;
`else
  assign stat_pause_cycles = 32'd0;
  assign stat_pause_events = 16'd0;
`endif

endmodule
`default_nettype wire
